// File: rtl/cdc_ingress_fifo.sv
// cdc_ingress_fifo: first-word-fall-through buffer in the source clock domain.
// It sits directly in front of the toggle-handshake crossing and absorbs
// producer bursts while the crossing moves one word at a time. A separate
// level counter keeps full and empty unambiguous. A peak watermark records
// the highest fill level for debug.
module cdc_ingress_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic [LW-1:0]         peak,
  input  logic                  peak_clr
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         peak_q, peak_d;
  logic                  push, pop;

  // Every status output is decoded from registered state only. A full
  // buffer refuses a push even when a pop happens in the same cycle.
  assign in_ready    = (level_q != LW'(DEPTH));
  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rdPtr_q];
  assign almost_full = (level_q >= LW'(AF_THRESH));
  assign level       = level_q;
  assign peak        = peak_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state logic for pointers, level and watermark.
  // Flush overrides everything, and it leaves peak alone.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    peak_d  = peak_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (peak_clr)              peak_d = level_d;
      else if (level_d > peak_q) peak_d = level_d;
    end
  end

  // Control state register. Storage contents are deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      peak_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      peak_q  <= peak_d;
    end
  end

  // Storage array write. A push is discarded when a flush occurs in the same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wrPtr_q] <= in_data;
  end

endmodule

// File: tb/tb_cdc_ingress_fifo.sv
// Directed testbench for cdc_ingress_fifo with DEPTH=8 and AF_THRESH=6.
module tb_cdc_ingress_fifo;

  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [LW-1:0] level;
  logic          almost_full;
  logic [LW-1:0] peak;
  logic          peak_clr;

  int passCount = 0;
  int totalCount = 0;

  cdc_ingress_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .level(level), .almost_full(almost_full),
    .peak(peak), .peak_clr(peak_clr)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs. Return 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic ordy, input logic fl, input logic pc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    peak_clr  = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expLevel;
    int expNextOut;
    int nextIn;
    int cycles;

    rst_n = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 0; flush = 0; peak_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_level", level, 0);
      checkOutput("idle_peak", peak, 0);
      checkOutput("idle_af", almost_full, 0);
    end

    // Fill to full with 0x00..0x07
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, DW'(i), 0, 0, 0);
      checkOutput("fill_level", level, i + 1);
      checkOutput("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      checkOutput("fill_in_ready", in_ready, (i + 1 < 8) ? 1 : 0);
      checkOutput("fill_out_valid", out_valid, 1);
      checkOutput("fill_head", out_data, 0);
    end
    applyStimulus(1, 32'h08, 0, 0, 0);
    checkOutput("full_refuse_level", level, 8);
    checkOutput("full_peak", peak, 8);
    checkOutput("full_head", out_data, 0);

    // Drain with concurrent pushes of 0x08..0x0F, expecting 0x00..0x0F
    expLevel = 8; expNextOut = 0; nextIn = 8; cycles = 0;
    while (expNextOut < 16 && cycles < 40) begin
      logic doPush;
      logic doPop;
      checkOutput("drain_level", level, expLevel);
      checkOutput("drain_in_ready", in_ready, (expLevel < 8) ? 1 : 0);
      checkOutput("drain_out_valid", out_valid, (expLevel > 0) ? 1 : 0);
      if (expLevel > 0) checkOutput("drain_data", out_data, expNextOut);
      doPush = (nextIn < 16) && (expLevel < 8);
      doPop  = (expLevel > 0);
      applyStimulus(nextIn < 16, DW'(nextIn), 1, 0, 0);
      if (doPush) begin nextIn++; expLevel++; end
      if (doPop)  begin expNextOut++; expLevel--; end
      cycles++;
    end
    checkOutput("drain_count", expNextOut, 16);
    checkOutput("drain_cycles", cycles, 16);
    checkOutput("drain_end_level", level, 0);
    checkOutput("drain_end_valid", out_valid, 0);

    // Empty-edge simultaneity
    applyStimulus(1, 32'hA5, 1, 0, 0);
    checkOutput("edge_level", level, 1);
    checkOutput("edge_valid", out_valid, 1);
    checkOutput("edge_data", out_data, 32'hA5);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("edge_pop_level", level, 0);
    checkOutput("edge_pop_valid", out_valid, 0);
    checkOutput("edge_peak", peak, 8);

    // Clear peak, fill to 5, then flush during a push/pop collision
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("pclr_peak0", peak, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, DW'(32'h50 + i), 0, 0, 0);
    checkOutput("pre_flush_level", level, 5);
    checkOutput("pre_flush_peak", peak, 5);
    checkOutput("pre_flush_head", out_data, 32'h50);
    applyStimulus(1, 32'h99, 1, 1, 0);
    checkOutput("flush_level", level, 0);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_peak", peak, 5);
    checkOutput("flush_in_ready", in_ready, 1);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("post_flush_valid", out_valid, 0);
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("post_flush_pclr", peak, 0);

    // Asynchronous reset in the middle of a burst at level 4
    for (int i = 0; i < 4; i++) applyStimulus(1, DW'(32'h40 + i), 0, 0, 0);
    checkOutput("pre_rst_level", level, 4);
    checkOutput("pre_rst_af", almost_full, 0);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_level", level, 0);
    checkOutput("async_rst_peak", peak, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 32'h3C, 0, 0, 0);
    checkOutput("after_rst_level", level, 1);
    checkOutput("after_rst_valid", out_valid, 1);
    checkOutput("after_rst_data", out_data, 32'h3C);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput("after_rst_pop_level", level, 0);
    checkOutput("after_rst_peak", peak, 1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
